// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state encoding and lane-order helper for the width-down serializers
package serializer_pkg;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   // Maps the running beat number onto the lane of the held word that goes out on that beat.
   function automatic int lane_index(input int beat_idx, input int ratio, input bit msb_first);
      return msb_first ? (ratio - 1 - beat_idx) : beat_idx;
   endfunction

endpackage

// File: rtl/lane_select.sv
// rtl/lane_select.sv - combinational lane mux from held word and beat number to one output beat
module lane_select
   import serializer_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter int MSB_FIRST = 0,
   parameter int RATIO     = IN_W / OUT_W,
   parameter int CNT_W     = $clog2(RATIO)
) (
   input  logic [IN_W-1:0]  word_i,
   input  logic [CNT_W-1:0] beat_idx_i,
   output logic [OUT_W-1:0] lane_o
);

   always_comb begin
      lane_o = '0;
      for (int l = 0; l < RATIO; l++) begin
         if (l == lane_index(int'(beat_idx_i), RATIO, MSB_FIRST != 0)) begin
            lane_o = word_i[l*OUT_W +: OUT_W];
         end
      end
   end

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - flow-controlled IN_W to OUT_W width-down converter with per-word beat count
module word_serializer
   import serializer_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter int MSB_FIRST = 0,
   parameter int RATIO     = IN_W / OUT_W,
   parameter int CNT_W     = $clog2(RATIO)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  in_data,
   input  logic [CNT_W-1:0] in_beats,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   // One extra bit so a full word (RATIO beats) fits in the down-counter.
   localparam logic [CNT_W:0]   FULL_BEATS = (CNT_W + 1)'(RATIO);
   localparam logic [CNT_W:0]   ONE_LEFT   = (CNT_W + 1)'(1);
   localparam logic [CNT_W-1:0] ONE_IDX    = CNT_W'(1);

   logic [0:0]       state_q, state_d;
   logic [IN_W-1:0]  word_q, word_d;
   logic [CNT_W-1:0] beat_idx_q, beat_idx_d;
   logic [CNT_W:0]   beats_left_q, beats_left_d;
   logic [OUT_W-1:0] lane;
   logic             sending;
   logic             beat_done;
   logic             accept;

   lane_select #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .MSB_FIRST (MSB_FIRST),
      .RATIO     (RATIO),
      .CNT_W     (CNT_W)
   ) u_lane_select (
      .word_i     (word_q),
      .beat_idx_i (beat_idx_q),
      .lane_o     (lane)
   );

   assign sending   = (state_q == SEND);
   assign out_valid = sending;
   assign out_last  = sending && (beats_left_q == ONE_LEFT);
   assign out_data  = sending ? lane : '0;
   assign busy      = sending;
   // Accepting on the final completing beat lets back-to-back words run without a bubble.
   assign in_ready  = !sending || (out_last && out_ready);
   assign beat_done = out_valid && out_ready;
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      beat_idx_d   = beat_idx_q;
      beats_left_d = beats_left_q;
      if (beat_done) begin
         beat_idx_d   = beat_idx_q + ONE_IDX;
         beats_left_d = beats_left_q - ONE_LEFT;
         if (out_last) begin
            state_d = IDLE;
         end
      end
      if (accept) begin
         word_d       = in_data;
         beat_idx_d   = '0;
         beats_left_d = (in_beats == '0) ? FULL_BEATS : {1'b0, in_beats};
         state_d      = SEND;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         word_q       <= '0;
         beat_idx_q   <= '0;
         beats_left_q <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         beat_idx_q   <= beat_idx_d;
         beats_left_q <= beats_left_d;
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - directed self-checking bench for word_serializer (LSB-first and MSB-first)
module tb_word_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_data = '0;
   logic [1:0]  in_beats = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_last, busy;
   logic [7:0]  out_data;
   logic        m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [7:0]  m_out_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] bp_exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic       bp_rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [7:0] b2b_exp [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

   always #5 clk = ~clk;

   word_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) u_lsb (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_beats  (in_beats),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   word_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1)) u_msb (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_beats  (in_beats),
      .in_valid  (in_valid),
      .in_ready  (m_in_ready),
      .out_data  (m_out_data),
      .out_valid (m_out_valid),
      .out_ready (out_ready),
      .out_last  (m_out_last),
      .busy      (m_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_last"}, 32'(out_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_data"}, 32'(out_data), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   // Called at a falling edge with both instances idle; sends one full word and checks both lane orders.
   task automatic send_full(input string tag, input logic [31:0] w,
                            input logic [7:0] l0, l1, l2, l3,
                            input logic [7:0] m0, m1, m2, m3);
      logic [7:0] le [4];
      logic [7:0] me [4];
      le = '{l0, l1, l2, l3};
      me = '{m0, m1, m2, m3};
      in_data   = w;
      in_beats  = 2'd0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 check({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
         check($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(le[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(out_last), 32'(i == 3));
         check($sformatf("%s_msb_data%0d", tag, i), 32'(m_out_data), 32'(me[i]));
         check($sformatf("%s_msb_last%0d", tag, i), 32'(m_out_last), 32'(i == 3));
         @(negedge clk);
      end
      check_idle({tag, "_done"});
      check({tag, "_msb_busy"}, 32'(m_busy), 32'd0);
   endtask

   initial begin
      int k;
      int c;

      @(negedge clk);
      check_idle("reset");
      check("reset_msb_valid", 32'(m_out_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      send_full("full", 32'hAABBCCDD, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hAA, 8'hBB, 8'hCC, 8'hDD);

      // Back-to-back: second word is offered the whole time the first one drains.
      in_data  = 32'h11223344;
      in_beats = 2'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_data = 32'h55667788;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("b2b_data%0d", i), 32'(out_data), 32'(b2b_exp[i]));
         check($sformatf("b2b_last%0d", i), 32'(out_last), 32'(i == 3 || i == 7));
         if (i < 4) check($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 32'(i == 3));
         if (i == 4) in_valid = 1'b0;
         @(negedge clk);
      end
      check_idle("b2b_done");

      // Backpressure with a partial word (2 beats) pending behind the stalled full word.
      in_data  = 32'hDEADBEEF;
      in_beats = 2'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_data  = 32'h0000BEEF;
      in_beats = 2'd2;
      k = 0;
      c = 0;
      while (k < 4 && c < 20) begin
         check($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
         check($sformatf("bp_data_c%0d", c), 32'(out_data), 32'(bp_exp[k]));
         check($sformatf("bp_last_c%0d", c), 32'(out_last), 32'(k == 3));
         out_ready = bp_rdy[c % 4];
         #1 check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(k == 3 && out_ready));
         if (out_ready) k++;
         c++;
         @(negedge clk);
      end
      check("bp_beats_done", 32'(k), 32'd4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("part_data0", 32'(out_data), 32'hEF);
      check("part_last0", 32'(out_last), 32'd0);
      @(negedge clk);
      check("part_data1", 32'(out_data), 32'hBE);
      check("part_last1", 32'(out_last), 32'd1);
      @(negedge clk);
      check_idle("part_done");

      // Reset in the middle of a word.
      in_data  = 32'hCAFEF00D;
      in_beats = 2'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_first_data", 32'(out_data), 32'h0D);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check("rst_async_valid", 32'(out_valid), 32'd0);
      check("rst_async_msb_valid", 32'(m_out_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("rst_release");
      send_full("after_rst", 32'h01020304, 8'h04, 8'h03, 8'h02, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parametrised width-down converter. Accepts one IN_W-bit word over a valid/ready handshake and emits it as a sequence of OUT_W-bit beats over a second valid/ready handshake.
- Lane order is selectable, and the beat count is selectable per word.
- Sits between the processor data path and narrow byte-oriented sinks (UART TX, debug/display output), replacing fixed free-running 32-to-8 rotation with flow-controlled transfer.

Parameters:
- IN_W, 32, input word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output beat width.
- MSB_FIRST, 0, 0 = lane 0 (bits OUT_W-1:0) sent first; 1 = top lane sent first.
- RATIO, IN_W/OUT_W, derived lanes per word; must be ≥2.
- CNT_W, clog2(RATIO), derived counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  word to serialize.
- in_beats  in  CNT_W  number of beats to emit for this word; 0 encodes RATIO (full word).
- in_valid  in  1  in_data/in_beats valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  OUT_W  current beat.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts beat this cycle.
- out_last  out  1  current beat is final beat of the word.
- busy  out  1  a word is held (state SEND).

Behaviour:
- Reset (async assert, sync release): state=IDLE, held word=0, beat_idx=0, beats_left=0. Outputs: out_valid=0, out_last=0, busy=0, out_data=0, in_ready=1.
- States: IDLE (nothing held) and SEND (word held, beats pending).
- Input handshake: a word is accepted when in_valid & in_ready at a clock edge.
- in_ready = (state==IDLE) | (state==SEND & out_last & out_ready). A new word may be loaded on the same edge the last beat of the previous word completes, so back-to-back words produce no bubble.
- On accept:
  - Latch in_data.
  - beats_left = (in_beats==0) ? RATIO : in_beats.
  - beat_idx = 0.
  - Go to SEND.
  - Latency: first beat is presented (out_valid=1) the cycle after accept.
- In SEND:
  - out_valid=1.
  - out_data = lane L of the held word: L = beat_idx when MSB_FIRST=0, L = RATIO-1-beat_idx when MSB_FIRST=1.
  - out_last = (beats_left==1).
- Output handshake: a beat completes when out_valid & out_ready. On completion, beat_idx+1 and beats_left-1.
  - After the last beat, go to IDLE, or stay in SEND with the new word if one is accepted on the same edge.
- Stall: with out_ready=0, out_data, out_last and all state hold indefinitely.
- Partial words: in_beats=k (1≤k<RATIO) emits only the first k lanes in the chosen order; the remaining lanes are dropped.
- In IDLE: out_data=0, out_last=0, out_valid=0.
- in_valid while SEND and not on the last completing beat: in_ready=0. The word is not taken and the source must hold it.
- Reset mid-word: the held word is discarded. out_valid drops asynchronously with reset and no further beats of that word appear.
- Throughput: 1 beat/cycle sustained with out_ready=1. A full word takes RATIO cycles.

Decomposition:
- Shared package serializer_pkg:
  - State encoding constants IDLE=1'b0, SEND=1'b1.
  - Helper function for lane index from beat_idx and MSB_FIRST.
- Sub-module lane_select (IN_W, OUT_W, MSB_FIRST): combinational mux from held word + beat_idx to out_data. Reused by later 16→8 and 64→8 instances.
- Handshake/counter FSM stays in word_serializer.

Test Plan:
- Full word, LSB-first: in_data=0xAABBCCDD, in_beats=0, out_ready=1.
  - Expect beats 0xDD, 0xCC, 0xBB, 0xAA on 4 consecutive cycles starting 1 cycle after accept.
  - out_last only on 0xAA, then busy=0.
- MSB_FIRST=1, same word: expect 0xAA, 0xBB, 0xCC, 0xDD.
- Back-to-back: 0x11223344 then 0x55667788 offered continuously with out_ready=1.
  - Expect 8 contiguous beats 44,33,22,11,88,77,66,55.
  - in_ready=1 on the cycle the 0x11 beat completes; no gap cycle.
- Backpressure: out_ready toggles 1,0,0,1,...
  - out_data holds during stalls, no beat repeated or skipped.
  - in_ready=0 while a new in_valid is pending mid-word.
- Partial word: in_data=0x0000BEEF, in_beats=2.
  - Expect 0xEF, 0xBE with out_last on 0xBE, then IDLE.
- Reset mid-word: assert reset after the first beat of 0xCAFEF00D.
  - out_valid=0 immediately and in_ready=1 after release.
  - Next word 0x01020304 emits 04,03,02,01 with no leftover CAFE beats.
